bus_arbit_rr: RTL
=================

// Module: bus_arbit_rr
// PURPOSE
//  N-master round-robin bus arbiter; generalises the two-master fixed-park arbiter to N_MST requesters.
//  Sits between master request lines and the shared bus mux.
//  Drives exactly one one-hot registered grant at all times; the bus is parked on master 0 when idle.
//  Downstream mux select is owner_id; arb_switch flags ownership hand-over for bus-side bookkeeping.
// PARAMETERS
//  N_MST     4   number of masters, 2..8
//  ID_W      2   owner_id width = clog2(N_MST)
//  MAX_HOLD  16  consecutive granted cycles before forced rotation (ARB_HOLD_LIMIT_EN only), 2..255
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       synchronous, active-high reset
//  req         in   N_MST   per-master bus request, level, held until transfer done
//  grant       out  N_MST   registered one-hot grant
//  owner_id    out  ID_W    binary index of the set grant bit
//  arb_switch  out  1       1-cycle pulse in the cycle grant differs from previous cycle
// BEHAVIOUR
//  Reset (reset=1 at posedge): grant=1 (master 0), owner_id=0, arb_switch=0, hold_cnt=0; req ignored.
//  All outputs registered; a grant change appears 1 clk after the req edge that caused it.
//  States: PARK (owner holds grant, req[owner]=0) and OWN (req[owner]=1); derived from req[owner].
//  OWN, req[owner]=1: keep grant (subject to hold limit).
//  req[owner]=0 and another req set: next owner = first set req scanning owner+1, owner+2, ... mod N_MST.
//  req[owner]=0 and req==0: next owner = master 0 (park); if owner already 0, grant unchanged, no pulse.
//  Simultaneous requests are resolved only by rotation order; there is no fixed priority except parking.
//  Master may drive the bus only in cycles where grant[i]=1 and req[i]=1.
//  Wrap-around: scan from owner N_MST-1 continues at 0.
//  arb_switch=1 only in the cycle after the grant register changed value; never on a reset cycle.
//  grant is never zero and never multi-hot; the verifier checks $onehot(grant) every cycle.
//  Reset mid-ownership: forced back to master 0 next edge regardless of req.
// CONFIGURATION
//  ARB_HOLD_LIMIT_EN defined:
//   - hold_cnt (8b) increments each cycle owner keeps grant with req[owner]=1; clears on owner change.
//   - When hold_cnt==MAX_HOLD-1 and any other req is set, the next edge rotates to the next requester
//     (same scan order) even though req[owner]=1; the preempted master re-requests normally.
//   - If no other req is set, hold_cnt saturates and the owner keeps the bus.
//  ARB_HOLD_LIMIT_EN undefined: no counter; owner keeps the bus until it drops req.
// STRUCTURE
//  Package bus_pkg: N_MST default, clog2-based ID_W, PARK_ID=0 constant, onehot-to-index function.
//  Sub-module rr_pick: combinational; inputs req and owner_id; outputs found and next_id.
//   - Rotate/priority scan excluding the current owner.
//  Top: grant/owner_id/arb_switch/hold_cnt registers plus next-state logic.
// TESTING
//  1 Reset with req=4'b1111 -> grant=0001, owner_id=0, arb_switch=0 for the whole reset; grant 0001 one clk after release.
//  2 Owner 0; req 0001->0110 (m0 drops) -> next clk grant=0010, arb_switch=1; m1 drops -> grant=0100.
//  3 Owner 3, req=0001 -> next grant=0001 (wrap); then req=0000 from owner 2 -> grant=0001 park, one pulse.
//  4 req=1111 held, each owner drops req for 1 clk in turn -> order 0,1,2,3,0; no master skipped or granted twice.
//  5 ARB_HOLD_LIMIT_EN, MAX_HOLD=16: m1 owns, req=0011 constant -> grant moves to m0 after 16 granted cycles.
//    Same test with req=0010 -> m1 keeps the bus.
//  6 Reset asserted while owner=2 with req=0100 -> grant=0001 next edge; $onehot(grant) holds throughout.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants and helpers for the round-robin bus arbiter.
package bus_pkg;

  localparam int N_MST_DEF = 4;
  localparam int ID_W_DEF  = $clog2(N_MST_DEF);
  localparam int PARK_ID   = 0;

  // PARK: owner has dropped req, OWN: owner is still requesting.
  typedef enum logic {
    PARK = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    onehot_to_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) onehot_to_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate scan: first requester after the current owner, wrapping, owner excluded.
module rr_pick #(
  parameter int N_MST = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_MST-1:0] req,
  input  logic [ID_W-1:0]  owner_id,
  output logic             found,
  output logic [ID_W-1:0]  next_id
);

  int              pos;
  logic [ID_W-1:0] sel;

  // Scan from the far end so the closest requester after the owner overwrites the rest.
  always_comb begin
    found   = 1'b0;
    next_id = owner_id;
    pos     = 0;
    sel     = '0;
    for (int k = N_MST - 1; k >= 1; k--) begin
      pos = (int'(owner_id) + k) % N_MST;
      sel = ID_W'(pos);
      if (req[sel]) begin
        found   = 1'b1;
        next_id = sel;
      end
    end
  end

endmodule

// File: rtl/bus_arbit_rr.sv
// N-master round-robin arbiter with a registered one-hot grant parked on master 0.
// Optional hold limit enabled by defining ARB_HOLD_LIMIT_EN.
module bus_arbit_rr
  import bus_pkg::*;
#(
  parameter int N_MST = N_MST_DEF,
  parameter int ID_W  = (N_MST > 1) ? $clog2(N_MST) : 1
`ifdef ARB_HOLD_LIMIT_EN
  ,
  parameter int MAX_HOLD = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_MST-1:0] req,
  output logic [N_MST-1:0] grant,
  output logic [ID_W-1:0]  owner_id,
  output logic             arb_switch
);

  // Handshake: req[i] is a level held for the whole transfer; master i may drive
  // the bus only in cycles where grant[i] and req[i] are both high.

  arb_state_e       state;
  logic             found;
  logic [ID_W-1:0]  next_id;
  logic [ID_W-1:0]  nxt_owner;
  logic [N_MST-1:0] nxt_grant;
`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0]       hold_cnt;
  logic [7:0]       hold_nxt;
`endif

  assign owner_id = ID_W'(onehot_to_idx(8'(grant)));

  rr_pick #(
    .N_MST (N_MST),
    .ID_W  (ID_W)
  ) u_pick (
    .req      (req),
    .owner_id (owner_id),
    .found    (found),
    .next_id  (next_id)
  );

  always_comb begin
    nxt_owner = owner_id;
    state     = req[owner_id] ? OWN : PARK;
`ifdef ARB_HOLD_LIMIT_EN
    hold_nxt  = '0;
`endif
    unique case (state)
      OWN: begin
`ifdef ARB_HOLD_LIMIT_EN
        // At the limit, hand over only if someone else waits; otherwise saturate.
        if (hold_cnt == 8'(MAX_HOLD - 1)) begin
          if (found) nxt_owner = next_id;
          else       hold_nxt  = hold_cnt;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
`else
        nxt_owner = owner_id;
`endif
      end
      PARK:    nxt_owner = found ? next_id : ID_W'(PARK_ID);
      default: nxt_owner = ID_W'(PARK_ID);
    endcase
    nxt_grant            = '0;
    nxt_grant[nxt_owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= N_MST'(1);
      arb_switch <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt   <= '0;
`endif
    end else begin
      grant      <= nxt_grant;
      arb_switch <= (nxt_grant != grant);
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt   <= hold_nxt;
`endif
    end
  end

endmodule
